// File: rtl/register_scoreboard.sv
// Register-file scoreboard: tracks in-flight destination registers, stalls issue on
// RAW/WAW hazards and arbitrates the single register-file write port (ALU over load).
module register_scoreboard #(
    parameter int unsigned SIZE     = 32,
    parameter bit          ZERO_REG = 1'b1,
    localparam int unsigned IDX_W   = $clog2(SIZE)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [IDX_W-1:0] issue_rs1,
    input  logic [IDX_W-1:0] issue_rs2,
    input  logic [IDX_W-1:0] issue_rd,
    input  logic             issue_use_rs1,
    input  logic             issue_use_rs2,
    input  logic             issue_has_rd,
    input  logic             wb_a_valid,
    input  logic [IDX_W-1:0] wb_a_rd,
    input  logic [31:0]      wb_a_data,
    input  logic             wb_b_valid,
    output logic             wb_b_ready,
    input  logic [IDX_W-1:0] wb_b_rd,
    input  logic [31:0]      wb_b_data,
    output logic             rf_enable,
    output logic [IDX_W-1:0] rf_rd,
    output logic [31:0]      rf_xd,
    output logic [IDX_W:0]   pending_count,
    output logic             idle,
    output logic             err
);

    logic [SIZE-1:0]  pending_q, pending_d;
    logic [IDX_W:0]   pending_count_q, pending_count_d;
    logic             err_q, err_d;

    logic             hazard;
    logic             set_en;
    logic             clr_en;
    logic             sel_valid;
    logic [IDX_W-1:0] sel_rd;
    logic [31:0]      sel_data;

    // Hazard looks only at registered state, so writebacks never reach issue_ready combinationally.
    always_comb begin
        hazard = (issue_use_rs1 & pending_q[issue_rs1])
               | (issue_use_rs2 & pending_q[issue_rs2])
               | (issue_has_rd  & pending_q[issue_rd]);
        issue_ready = ~reset & ~hazard;
        set_en = issue_valid & issue_ready & issue_has_rd
               & ~(ZERO_REG && (issue_rd == '0));
    end

    always_comb begin
        if (wb_a_valid) begin
            sel_valid  = 1'b1;
            sel_rd     = wb_a_rd;
            sel_data   = wb_a_data;
            wb_b_ready = 1'b0;
        end else begin
            sel_valid  = wb_b_valid;
            sel_rd     = wb_b_rd;
            sel_data   = wb_b_data;
            wb_b_ready = ~reset;
        end
        rf_enable = ~reset & sel_valid & ~(ZERO_REG && (sel_rd == '0));
        rf_rd     = reset ? '0 : sel_rd;
        rf_xd     = reset ? '0 : sel_data;
    end

    // Only a clear of a bit that was actually set moves the count, so stray commits cannot wrap it.
    always_comb begin
        clr_en    = rf_enable & pending_q[rf_rd];
        err_d     = err_q | (rf_enable & ~pending_q[rf_rd]);
        pending_d = pending_q;
        if (rf_enable) begin
            pending_d[rf_rd] = 1'b0;
        end
        if (set_en) begin
            pending_d[issue_rd] = 1'b1;
        end
        case ({set_en, clr_en})
            2'b10:   pending_count_d = pending_count_q + 1'b1;
            2'b01:   pending_count_d = pending_count_q - 1'b1;
            default: pending_count_d = pending_count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q       <= '0;
            pending_count_q <= '0;
            err_q           <= 1'b0;
        end else begin
            pending_q       <= pending_d;
            pending_count_q <= pending_count_d;
            err_q           <= err_d;
        end
    end

    assign pending_count = pending_count_q;
    assign idle          = (pending_count_q == '0);
    assign err           = err_q;

endmodule

// File: tb/tb_register_scoreboard.sv
// Directed bench for register_scoreboard: issue stalls, write-port arbitration,
// zero register, error flag and asynchronous reset.
module tb_register_scoreboard;

    localparam int unsigned IDX_W = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic             issue_valid;
    logic             issue_ready;
    logic [IDX_W-1:0] issue_rs1, issue_rs2, issue_rd;
    logic             issue_use_rs1, issue_use_rs2, issue_has_rd;
    logic             wb_a_valid;
    logic [IDX_W-1:0] wb_a_rd;
    logic [31:0]      wb_a_data;
    logic             wb_b_valid;
    logic             wb_b_ready;
    logic [IDX_W-1:0] wb_b_rd;
    logic [31:0]      wb_b_data;
    logic             rf_enable;
    logic [IDX_W-1:0] rf_rd;
    logic [31:0]      rf_xd;
    logic [IDX_W:0]   pending_count;
    logic             idle;
    logic             err;

    int unsigned checks = 0;
    int unsigned errors = 0;

    register_scoreboard #(.SIZE(32), .ZERO_REG(1'b1)) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd),
        .issue_use_rs1(issue_use_rs1), .issue_use_rs2(issue_use_rs2),
        .issue_has_rd(issue_has_rd),
        .wb_a_valid(wb_a_valid), .wb_a_rd(wb_a_rd), .wb_a_data(wb_a_data),
        .wb_b_valid(wb_b_valid), .wb_b_ready(wb_b_ready),
        .wb_b_rd(wb_b_rd), .wb_b_data(wb_b_data),
        .rf_enable(rf_enable), .rf_rd(rf_rd), .rf_xd(rf_xd),
        .pending_count(pending_count), .idle(idle), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance one clock edge and land 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_issue();
        issue_valid = 0; issue_use_rs1 = 0; issue_use_rs2 = 0; issue_has_rd = 0;
        issue_rs1 = '0; issue_rs2 = '0; issue_rd = '0;
    endtask

    // probe a register's pending bit through the read-hazard path (no accept)
    task automatic probe(input string tag, input logic [IDX_W-1:0] r, input logic exp_ready);
        clear_issue();
        issue_use_rs1 = 1; issue_rs1 = r;
        #1;
        check(tag, {31'b0, issue_ready}, {31'b0, exp_ready});
        clear_issue();
    endtask

    initial begin
        reset = 1;
        clear_issue();
        wb_a_valid = 1; wb_a_rd = 5'd5; wb_a_data = 32'hFFFF_0000;
        wb_b_valid = 1; wb_b_rd = 5'd6; wb_b_data = 32'h1111_2222;
        issue_valid = 1; issue_has_rd = 1; issue_rd = 5'd8;
        #2;
        check("rst_issue_ready", {31'b0, issue_ready}, 32'd0);
        check("rst_wb_b_ready", {31'b0, wb_b_ready}, 32'd0);
        check("rst_rf_enable", {31'b0, rf_enable}, 32'd0);
        check("rst_rf_rd", {27'b0, rf_rd}, 32'd0);
        check("rst_rf_xd", rf_xd, 32'd0);
        check("rst_count", {26'b0, pending_count}, 32'd0);
        check("rst_idle", {31'b0, idle}, 32'd1);
        check("rst_err", {31'b0, err}, 32'd0);
        tick();
        tick();
        clear_issue();
        wb_a_valid = 0; wb_b_valid = 0;
        reset = 0;
        tick();
        check("rel_count", {26'b0, pending_count}, 32'd0);

        // 1: issue rd=5
        issue_valid = 1; issue_has_rd = 1; issue_rd = 5'd5;
        #1;
        check("t1_ready", {31'b0, issue_ready}, 32'd1);
        tick();
        clear_issue();
        check("t1_count", {26'b0, pending_count}, 32'd1);
        check("t1_idle", {31'b0, idle}, 32'd0);
        issue_has_rd = 1; issue_rd = 5'd5;
        #1;
        check("t1_waw_stall", {31'b0, issue_ready}, 32'd0);
        clear_issue();

        // 2: RAW on x5, A commits x5; ready rises only after the edge
        issue_valid = 1; issue_use_rs1 = 1; issue_rs1 = 5'd5;
        #1;
        check("t2_raw_stall", {31'b0, issue_ready}, 32'd0);
        wb_a_valid = 1; wb_a_rd = 5'd5; wb_a_data = 32'hA5A5_A5A5;
        #1;
        check("t2_same_cycle", {31'b0, issue_ready}, 32'd0);
        check("t2_rf_enable", {31'b0, rf_enable}, 32'd1);
        check("t2_rf_rd", {27'b0, rf_rd}, 32'd5);
        check("t2_rf_xd", rf_xd, 32'hA5A5_A5A5);
        check("t2_b_ready", {31'b0, wb_b_ready}, 32'd0);
        tick();
        wb_a_valid = 0;
        #1;
        check("t2_ready_next", {31'b0, issue_ready}, 32'd1);
        check("t2_count", {26'b0, pending_count}, 32'd0);
        check("t2_err", {31'b0, err}, 32'd0);
        tick();
        clear_issue();

        // 3: make x3,x7 pending, then A and B collide
        issue_valid = 1; issue_has_rd = 1; issue_rd = 5'd3;
        tick();
        issue_rd = 5'd7;
        tick();
        clear_issue();
        check("t3_count2", {26'b0, pending_count}, 32'd2);
        wb_a_valid = 1; wb_a_rd = 5'd3; wb_a_data = 32'h0000_0033;
        wb_b_valid = 1; wb_b_rd = 5'd7; wb_b_data = 32'h0000_0077;
        #1;
        check("t3_c1_rf_rd", {27'b0, rf_rd}, 32'd3);
        check("t3_c1_rf_xd", rf_xd, 32'h33);
        check("t3_c1_b_ready", {31'b0, wb_b_ready}, 32'd0);
        tick();
        wb_a_valid = 0;
        #1;
        check("t3_c2_rf_rd", {27'b0, rf_rd}, 32'd7);
        check("t3_c2_rf_xd", rf_xd, 32'h77);
        check("t3_c2_b_ready", {31'b0, wb_b_ready}, 32'd1);
        check("t3_c2_rf_enable", {31'b0, rf_enable}, 32'd1);
        check("t3_c2_count", {26'b0, pending_count}, 32'd1);
        tick();
        wb_b_valid = 0;
        check("t3_count0", {26'b0, pending_count}, 32'd0);
        check("t3_err", {31'b0, err}, 32'd0);
        probe("t3_x3_free", 5'd3, 1'b1);
        probe("t3_x7_free", 5'd7, 1'b1);

        // 4: issue rd=9 while A commits pending x4
        issue_valid = 1; issue_has_rd = 1; issue_rd = 5'd4;
        tick();
        issue_rd = 5'd9;
        wb_a_valid = 1; wb_a_rd = 5'd4; wb_a_data = 32'h4444_4444;
        tick();
        wb_a_valid = 0;
        clear_issue();
        check("t4_count", {26'b0, pending_count}, 32'd1);
        probe("t4_x9_pending", 5'd9, 1'b0);
        probe("t4_x4_free", 5'd4, 1'b1);
        wb_a_valid = 1; wb_a_rd = 5'd9; wb_a_data = 32'h9;
        tick();
        wb_a_valid = 0;
        check("t4_drain", {26'b0, pending_count}, 32'd0);

        // 5: zero register
        issue_valid = 1; issue_has_rd = 1; issue_rd = 5'd0;
        #1;
        check("t5_ready", {31'b0, issue_ready}, 32'd1);
        tick();
        clear_issue();
        check("t5_count_issue", {26'b0, pending_count}, 32'd0);
        wb_a_valid = 1; wb_a_rd = 5'd0; wb_a_data = 32'hDEAD_BEEF;
        #1;
        check("t5_a_rf_enable", {31'b0, rf_enable}, 32'd0);
        tick();
        wb_a_valid = 0;
        wb_b_valid = 1; wb_b_rd = 5'd0; wb_b_data = 32'hBEEF;
        #1;
        check("t5_b_rf_enable", {31'b0, rf_enable}, 32'd0);
        check("t5_b_ready", {31'b0, wb_b_ready}, 32'd1);
        tick();
        wb_b_valid = 0;
        check("t5_count", {26'b0, pending_count}, 32'd0);
        check("t5_err", {31'b0, err}, 32'd0);

        // 6: stray commit sets err, then reset mid-stream
        wb_b_valid = 1; wb_b_rd = 5'd12; wb_b_data = 32'h1212_1212;
        #1;
        check("t6_rf_enable", {31'b0, rf_enable}, 32'd1);
        check("t6_rf_rd", {27'b0, rf_rd}, 32'd12);
        tick();
        wb_b_valid = 0;
        check("t6_err", {31'b0, err}, 32'd1);
        check("t6_count", {26'b0, pending_count}, 32'd0);
        issue_valid = 1; issue_has_rd = 1; issue_rd = 5'd20;
        tick();
        clear_issue();
        check("t6_count1", {26'b0, pending_count}, 32'd1);
        #2;
        reset = 1;
        #1;
        check("t6_rst_err", {31'b0, err}, 32'd0);
        check("t6_rst_count", {26'b0, pending_count}, 32'd0);
        check("t6_rst_idle", {31'b0, idle}, 32'd1);
        tick();
        check("t6_rst_held", {26'b0, pending_count}, 32'd0);
        reset = 0;
        probe("t6_x20_dropped", 5'd20, 1'b1);
        wb_a_valid = 1; wb_a_rd = 5'd20; wb_a_data = 32'h2020;
        #1;
        check("t6_late_enable", {31'b0, rf_enable}, 32'd1);
        tick();
        wb_a_valid = 0;
        check("t6_late_err", {31'b0, err}, 32'd1);
        check("t6_late_count", {26'b0, pending_count}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
